mem_arbiter: RTL

- Shares the single-port 256x24 cube-state memory (one address, one write enable, combinational read data) between two requesters: port 0, the solver engine, and port 1, the host/display readout.
- Round-robin arbitration grants at most one access per cycle.
- A built-in clear sequencer zeroes the whole memory on command, so state can be wiped without asserting the global reset.
- Sits directly between the requesters and the memory instance.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// =====================================================================
// mem_arbiter: round-robin two-port arbiter plus whole-memory clear
//              sequencer in front of the single-port cube-state memory.
// Revision: 1.0
// =====================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DW  = 24,
    parameter int AW  = 8,
    parameter int MAW = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_start,
    output logic           clr_busy,
    input  logic           req0,
    input  logic           we0,
    input  logic [AW-1:0]  addr0,
    input  logic [DW-1:0]  wdata0,
    output logic           gnt0,
    output logic           rvalid0,
    output logic [DW-1:0]  rdata0,
    input  logic           req1,
    input  logic           we1,
    input  logic [AW-1:0]  addr1,
    input  logic [DW-1:0]  wdata1,
    output logic           gnt1,
    output logic           rvalid1,
    output logic [DW-1:0]  rdata1,
    output logic           mem_we,
    output logic [MAW-1:0] mem_addr,
    output logic [DW-1:0]  mem_in,
    input  logic [DW-1:0]  mem_out
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic            last_gnt_q;
    logic            clr_busy_q;
    logic            rvalid0_q;
    logic            rvalid1_q;
    logic [DW-1:0]   rdata0_q;
    logic [DW-1:0]   rdata1_q;
    logic            arb_en;

    // A clear request pre-empts arbitration in the same cycle.
    assign arb_en = (state_q == S_IDLE) && !clr_start;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_en) begin
            if (req0 && req1) begin
                gnt0 = last_gnt_q;
                gnt1 = !last_gnt_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_in   = '0;
        if (state_q == S_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = MAW'(clr_cnt_q);
        end else if (gnt0) begin
            mem_we   = we0;
            mem_addr = MAW'(addr0);
            mem_in   = wdata0;
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = MAW'(addr1);
            mem_in   = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            last_gnt_q <= 1'b1;
            clr_busy_q <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            rvalid0_q <= gnt0 && !we0;
            rvalid1_q <= gnt1 && !we1;
            if (gnt0 && !we0) begin
                rdata0_q <= mem_out;
            end
            if (gnt1 && !we1) begin
                rdata1_q <= mem_out;
            end
            if (gnt0) begin
                last_gnt_q <= 1'b0;
            end else if (gnt1) begin
                last_gnt_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (clr_start) begin
                        state_q    <= S_CLEAR;
                        clr_busy_q <= 1'b1;
                        clr_cnt_q  <= '0;
                    end
                end
                S_CLEAR: begin
                    // Counter wraps back to zero as the last address is written.
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q    <= S_IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

`default_nettype wire
